// File: rtl/uart_pkg.sv
// uart_pkg: shared widths and types for the UART receive path.
// Optional UART_RX_FIFO_FERR_EN widens FIFO entries by a frame-error tag bit.
package uart_pkg;

   localparam int BYTE_W        = 8;
   localparam int RX_FIFO_DEPTH = 16;
   localparam int BYTE_CNT_W    = 14;

   typedef logic [BYTE_W-1:0]     byte_t;
   typedef logic [BYTE_CNT_W-1:0] byte_cnt_t;

   // Stored entry width: payload, plus the error tag when enabled.
   function automatic int entry_w(input int data_w);
`ifdef UART_RX_FIFO_FERR_EN
      return data_w + 1;
`else
      return data_w;
`endif
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver write strobe and consumer read handshake.
// UART_RX_FIFO_FERR_EN adds wr_ferr / rd_ferr alongside the data.
interface uart_rx_fifo_if
   import uart_pkg::*;
#(
   parameter int DATA_W = BYTE_W
);

   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              rd_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
`ifdef UART_RX_FIFO_FERR_EN
   logic              wr_ferr;
   logic              rd_ferr;

   modport master (
      output wr_valid, wr_data, wr_ferr, rd_ready,
      input  rd_valid, rd_data, rd_ferr
   );

   modport slave (
      input  wr_valid, wr_data, wr_ferr, rd_ready,
      output rd_valid, rd_data, rd_ferr
   );
`else
   modport master (
      output wr_valid, wr_data, rd_ready,
      input  rd_valid, rd_data
   );

   modport slave (
      input  wr_valid, wr_data, rd_ready,
      output rd_valid, rd_data
   );
`endif

endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x WIDTH register array, one synchronous write
// port and one combinational read port; contents are never reset.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = RX_FIFO_DEPTH,
   parameter int WIDTH = BYTE_W
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Store the incoming entry at the write address.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT byte buffer behind the UART receiver with occupancy,
// sticky overflow and accepted-byte counter. Option: UART_RX_FIFO_FERR_EN.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = RX_FIFO_DEPTH,
   parameter int DATA_W = BYTE_W
) (
   input  logic                   clk,
   input  logic                   rst,
   uart_rx_fifo_if.slave          bus,
   input  logic                   ovf_clr,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   ovf,
   output byte_cnt_t              byte_total
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = entry_w(DATA_W);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic             drop;
   logic [ENT_W-1:0] wdata;
   logic [ENT_W-1:0] rdata;

   assign empty        = (count == '0);
   assign full         = (count == CNT_FULL);
   assign bus.rd_valid = ~empty;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts.
   assign pop  = bus.rd_ready & ~empty;
   assign push = bus.wr_valid & (~full | pop);
   assign drop = bus.wr_valid & full & ~pop;

`ifdef UART_RX_FIFO_FERR_EN
   assign wdata       = {bus.wr_ferr, bus.wr_data};
   assign bus.rd_data = rdata[DATA_W-1:0];
   // Masked so the tag reads 0 after reset while memory is stale.
   assign bus.rd_ferr = rdata[DATA_W] & ~empty;
`else
   assign wdata       = bus.wr_data;
   assign bus.rd_data = rdata;
`endif

   uart_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_mem (
      .clk   (clk),
      .we    (push & ~rst),
      .waddr (wr_ptr),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   // Advance write/read pointers; they wrap naturally modulo DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Occupancy: net change of simultaneous push and pop is zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else begin
         unique case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow; a drop wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end

   // Count accepted bytes only; wraps at 2^BYTE_CNT_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_total <= '0;
      end else if (push) begin
         byte_total <= byte_total + byte_cnt_t'(1);
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed plus random stimulus for uart_rx_fifo,
// checked against a queue-based model of the buffer.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            ovf_clr = 1'b0;
   logic [4:0]      count;
   logic            full;
   logic            empty;
   logic            ovf;
   logic [13:0]     byte_total;

   uart_rx_fifo_if #(.DATA_W(8)) bus ();

   uart_rx_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .ovf_clr    (ovf_clr),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .ovf        (ovf),
      .byte_total (byte_total)
   );

   always #5 clk = ~clk;

   logic [8:0] q[$];
   int         m_total;
   bit         m_ovf;
   int         checks;
   int         errors;
   bit         quiet;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      chk("count", 32'(count), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("rd_valid", 32'(bus.rd_valid), 32'(q.size() != 0));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("byte_total", 32'(byte_total), 32'(m_total));
`ifdef UART_RX_FIFO_FERR_EN
      if (q.size() == 0) chk("rd_ferr_idle", 32'(bus.rd_ferr), 32'(0));
`endif
   endtask

   task automatic step(input bit wv, input logic [7:0] wd, input bit ferr,
                       input bit rr, input bit clr);
      bit pop;
      bit push;
      bit drop;
      bus.wr_valid = wv;
      bus.wr_data  = wd;
      bus.rd_ready = rr;
      ovf_clr      = clr;
`ifdef UART_RX_FIFO_FERR_EN
      bus.wr_ferr  = ferr;
`endif
      #1;
      if (!quiet && q.size() != 0) begin
         chk("rd_data", 32'(bus.rd_data), 32'(q[0][7:0]));
`ifdef UART_RX_FIFO_FERR_EN
         chk("rd_ferr", 32'(bus.rd_ferr), 32'(q[0][8]));
`endif
      end
      pop  = rr && (q.size() != 0);
      push = wv && (q.size() < DEPTH || pop);
      drop = wv && !push;
      if (pop) void'(q.pop_front());
      if (push) begin
         q.push_back({ferr, wd});
         m_total = (m_total + 1) % 16384;
      end
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      @(posedge clk);
      #1;
      if (!quiet) check_state();
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'hEE;
      bus.rd_ready = 1'b0;
      ovf_clr      = 1'b0;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.wr_valid = 1'b0;
      q.delete();
      m_total = 0;
      m_ovf   = 1'b0;
      check_state();
   endtask

   logic [7:0] pat [4];

   initial begin
      pat = '{8'h53, 8'h6E, 8'h61, 8'h70};
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.rd_ready = 1'b0;
`ifdef UART_RX_FIFO_FERR_EN
      bus.wr_ferr  = 1'b0;
`endif
      quiet = 1'b0;

      do_reset();

      for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      do_reset();
      for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);

      step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 120; i++) begin
         step($urandom_range(0, 3) != 0, 8'($urandom), 1'b0,
              $urandom_range(0, 1) != 0, $urandom_range(0, 7) == 0);
      end
      do_reset();

      quiet = 1'b1;
      for (int i = 0; i < 16387; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
      quiet = 1'b0;
      check_state();
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

`ifdef UART_RX_FIFO_FERR_EN
      do_reset();
      step(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
